fetch_sequencer: RTL and testbench

Sequencing controller for the 8-bit processor's instruction fetch. Owns the program counter and issues instruction-memory reads with a request/grant/response handshake. Holds each fetched byte for the decoder under a valid/ready handshake, and applies branch redirects and HALT from the execute/decode stages. Sits between instruction memory and decode and replaces free-running PC increment with stall-, redirect- and halt-aware sequencing.

---
 rtl/fetch_sequencer_if.sv | 40 ++++
 rtl/fetch_sequencer.sv | 141 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Bundle of the fetch sequencer's memory, decode and control signals.
// master = sequencer side, slave = memory/decode/execute side.
interface fetch_sequencer_if;
  // Handshakes: imem request transfers in a cycle with imem_req & imem_gnt; each
  // granted request returns exactly one imem_rvalid pulse, at least one cycle
  // later. The instruction transfers in a cycle with instr_valid & instr_ready;
  // instr_data/instr_pc are held stable while instr_valid is high.
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_gnt;
  logic       imem_rvalid;
  logic [7:0] imem_rdata;
  logic       instr_valid;
  logic [7:0] instr_data;
  logic [7:0] instr_pc;
  logic       instr_ready;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       halt;
  logic       halted;
  logic [7:0] pc;
  logic       push_ret;
  logic       pop_ret;
  logic       ras_err;
  logic [2:0] state;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_data, instr_pc, halted, pc,
           ras_err, state,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect,
           redirect_pc, halt, push_ret, pop_ret
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_data, instr_pc, halted, pc,
           ras_err, state,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect,
           redirect_pc, halt, push_ret, pop_ret
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC ownership, imem request/response, decode hand-off.
// Optional return-address stack enabled by defining FETCH_SEQ_RAS_EN.
module fetch_sequencer #(
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter int         RAS_DEPTH = 4
) (
  input logic               clk,
  input logic               reset,
  fetch_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_WAIT  = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t     r_state;
  logic [7:0] r_pc;
  logic [7:0] r_instr_data;
  logic [7:0] r_instr_pc;

  logic       w_halt_take;
  logic       w_accept;
  logic       w_redir;
  logic [7:0] w_target;

  // Halt wins over any redirect presented in the same handshake cycle.
  assign w_halt_take = (r_state == S_ISSUE) && bus.instr_ready && bus.halt;
  assign w_accept    = ((r_state == S_FETCH) || (r_state == S_WAIT) ||
                        (r_state == S_ISSUE)) && !w_halt_take;

`ifdef FETCH_SEQ_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [7:0]  r_ras [RAS_DEPTH];
  logic [PW-1:0] r_top;
  logic [PW:0] r_cnt;
  logic        r_ras_err;
  logic [PW-1:0] w_top_m1;
  logic        w_push;
  logic        w_pop;
  logic        w_empty;
  logic        w_full;

  assign w_top_m1 = r_top - 1'b1;
  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == (PW+1)'(RAS_DEPTH));
  assign w_pop    = bus.pop_ret && w_accept;
  assign w_push   = bus.redirect && bus.push_ret && !bus.pop_ret && w_accept;
  assign w_redir  = bus.redirect || bus.pop_ret;
  assign w_target = bus.pop_ret ? (w_empty ? RESET_PC : r_ras[w_top_m1])
                                : bus.redirect_pc;
  assign bus.ras_err = r_ras_err;

  // Circular buffer: when full, the write slot is the oldest entry, so a push
  // overwrites it without any shifting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= 8'h00;
      r_top     <= '0;
      r_cnt     <= '0;
      r_ras_err <= 1'b0;
    end else if (w_pop) begin
      if (w_empty) begin
        r_ras_err <= 1'b1;
      end else begin
        r_top <= w_top_m1;
        r_cnt <= r_cnt - 1'b1;
      end
    end else if (w_push) begin
      r_ras[r_top] <= r_instr_pc + 8'h01;
      r_top        <= r_top + 1'b1;
      if (w_full) r_ras_err <= 1'b1;
      else        r_cnt     <= r_cnt + 1'b1;
    end
  end
`else
  logic w_unused_ras;
  assign w_unused_ras = bus.push_ret ^ bus.pop_ret;
  assign w_redir      = bus.redirect;
  assign w_target     = bus.redirect_pc;
  assign bus.ras_err  = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_instr_data <= 8'h00;
      r_instr_pc   <= 8'h00;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_redir) begin
            r_pc    <= w_target;
            r_state <= bus.imem_gnt ? S_DRAIN : S_FETCH;
          end else if (bus.imem_gnt) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_redir) begin
            r_pc    <= w_target;
            r_state <= bus.imem_rvalid ? S_FETCH : S_DRAIN;
          end else if (bus.imem_rvalid) begin
            r_instr_data <= bus.imem_rdata;
            r_instr_pc   <= r_pc;
            r_pc         <= r_pc + 8'h01;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_halt_take) begin
            r_state <= S_HALT;
          end else if (w_redir) begin
            r_pc    <= w_target;
            r_state <= S_FETCH;
          end else if (bus.instr_ready) begin
            r_state <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (bus.imem_rvalid) r_state <= S_FETCH;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign bus.imem_req    = (r_state == S_FETCH);
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = (r_state == S_ISSUE);
  assign bus.instr_data  = r_instr_data;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.halted      = (r_state == S_HALT);
  assign bus.pc          = r_pc;
  assign bus.state       = r_state;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (default and FETCH_SEQ_RAS_EN builds).
module tb_fetch_sequencer;
  logic clk;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(8'h00), .RAS_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Leaves the DUT in ISSUE presenting (data, addr); the caller owns the next edge.
  task automatic fetch_to_issue(input logic [7:0] data, input logic [7:0] addr);
    chk("req_in_fetch", bus.imem_req, 8'h01);
    chk("imem_addr", bus.imem_addr, addr);
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    chk("req_in_wait", bus.imem_req, 8'h00);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = data;
    tick();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 8'h00;
    chk("instr_valid", bus.instr_valid, 8'h01);
    chk("instr_data", bus.instr_data, data);
    chk("instr_pc", bus.instr_pc, addr);
  endtask

  task automatic fetch_one(input logic [7:0] data, input logic [7:0] addr);
    fetch_to_issue(data, addr);
    tick();
  endtask

  initial begin
    reset           = 1'b1;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 8'h00;
    bus.instr_ready = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 8'h00;
    bus.halt        = 1'b0;
    bus.push_ret    = 1'b0;
    bus.pop_ret     = 1'b0;
    #1;
    chk("rst_pc", bus.pc, 8'h00);
    chk("rst_instr_valid", bus.instr_valid, 8'h00);
    chk("rst_instr_data", bus.instr_data, 8'h00);
    chk("rst_instr_pc", bus.instr_pc, 8'h00);
    chk("rst_halted", bus.halted, 8'h00);
    chk("rst_ras_err", bus.ras_err, 8'h00);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("req_after_reset", bus.imem_req, 8'h01);

    // Back-to-back fetches on a 3-cycle cadence.
    fetch_one(8'h10, 8'h00);
    fetch_one(8'h11, 8'h01);
    fetch_one(8'h12, 8'h02);

    // Decode stall: outputs hold, no new request.
    bus.instr_ready = 1'b0;
    fetch_to_issue(8'h5C, 8'h03);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", bus.instr_valid, 8'h01);
      chk("stall_data", bus.instr_data, 8'h5C);
      chk("stall_pc", bus.instr_pc, 8'h03);
      chk("stall_req", bus.imem_req, 8'h00);
    end
    bus.instr_ready = 1'b1;
    tick();
    chk("post_stall_req", bus.imem_req, 8'h01);
    chk("post_stall_addr", bus.imem_addr, 8'h04);

    // Redirect while waiting; the late response must be discarded.
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt    = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h40;
    tick();
    bus.redirect = 1'b0;
    chk("drain_req", bus.imem_req, 8'h00);
    chk("drain_valid", bus.instr_valid, 8'h00);
    tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 8'hAA;
    chk("drain_valid2", bus.instr_valid, 8'h00);
    tick();
    bus.imem_rvalid = 1'b0;
    chk("discard_valid", bus.instr_valid, 8'h00);
    chk("discard_pc", bus.pc, 8'h40);
    fetch_one(8'h77, 8'h40);

    // Redirect in FETCH without grant takes effect next cycle; then PC wrap.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'hFF;
    tick();
    bus.redirect = 1'b0;
    fetch_one(8'hE0, 8'hFF);
    chk("wrap_req", bus.imem_req, 8'h01);
    chk("wrap_addr", bus.imem_addr, 8'h00);

`ifdef FETCH_SEQ_RAS_EN
    // CALL from 8'h20 to 8'h80, then return to 8'h21.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h20;
    tick();
    bus.redirect = 1'b0;
    fetch_to_issue(8'hC0, 8'h20);
    bus.redirect    = 1'b1;
    bus.push_ret    = 1'b1;
    bus.redirect_pc = 8'h80;
    tick();
    bus.redirect = 1'b0;
    bus.push_ret = 1'b0;
    fetch_one(8'h01, 8'h80);
    bus.pop_ret = 1'b1;
    tick();
    bus.pop_ret = 1'b0;
    chk("ret_addr", bus.imem_addr, 8'h21);
    chk("ret_err", bus.ras_err, 8'h00);
    // Five pushes into a four-deep stack.
    bus.redirect    = 1'b1;
    bus.push_ret    = 1'b1;
    bus.redirect_pc = 8'h30;
    for (int i = 0; i < 4; i++) tick();
    chk("push4_err", bus.ras_err, 8'h00);
    tick();
    bus.redirect = 1'b0;
    bus.push_ret = 1'b0;
    chk("push5_err", bus.ras_err, 8'h01);
    tick();
    chk("err_sticky", bus.ras_err, 8'h01);
`else
    // Stack controls are ignored: pop does nothing, push only redirects.
    bus.pop_ret = 1'b1;
    tick();
    bus.pop_ret = 1'b0;
    chk("pop_ignored_addr", bus.imem_addr, 8'h00);
    bus.redirect    = 1'b1;
    bus.push_ret    = 1'b1;
    bus.redirect_pc = 8'h30;
    for (int i = 0; i < 5; i++) tick();
    bus.redirect = 1'b0;
    bus.push_ret = 1'b0;
    chk("push_redirect_addr", bus.imem_addr, 8'h30);
    chk("ras_err_tied", bus.ras_err, 8'h00);
`endif

    // Halt on handshake at 8'h05 with a competing redirect.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h05;
    tick();
    bus.redirect = 1'b0;
    fetch_to_issue(8'hF0, 8'h05);
    bus.halt        = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h99;
    tick();
    bus.halt     = 1'b0;
    bus.redirect = 1'b0;
    chk("halted", bus.halted, 8'h01);
    chk("halt_valid", bus.instr_valid, 8'h00);
    chk("halt_pc", bus.pc, 8'h06);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_req", bus.imem_req, 8'h00);
      chk("halt_hold", bus.halted, 8'h01);
    end
    reset = 1'b1;
    #1;
    chk("rerst_pc", bus.pc, 8'h00);
    chk("rerst_halted", bus.halted, 8'h00);
    chk("rerst_ras_err", bus.ras_err, 8'h00);
    tick();
    reset = 1'b0;
    tick();
    chk("rerst_req", bus.imem_req, 8'h01);
    chk("rerst_addr", bus.imem_addr, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
